multichannel_fir_filter: RTL and testbench
==========================================

Name: multichannel_fir_filter

Overview:
- Multi-channel streaming FIR filter for the motor current-sense path; successor to the fixed-function current filter.
- Adds parametrised tap count, runtime-writable coefficients, optional decimation, and round/saturate output.
- One time-shared multiply-accumulate unit serves all channels; valid/ready streaming on both sides.
- Sits between the ADC sample aggregator and the current control loop.

Parameters:
- DATA_WIDTH, 16: signed sample width per channel.
- DATA_COUNT, 2: number of channels packed in one beat.
- TAP_COUNT, 8: taps per channel, ≥2. Coefficients are shared by all channels.
- COEF_WIDTH, 16: signed coefficient width.
- COEF_FRAC, 15: fractional bits of a coefficient, 1..COEF_WIDTH-1.
- DECIMATION, 1: one output per DECIMATION accepted inputs, ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_data  in  DATA_WIDTH*DATA_COUNT  channel 0 in MSBs, channel DATA_COUNT-1 in LSBs.
- in_valid  in  1  input beat valid.
- in_ready  out  1  filter can accept a beat.
- out_data  out  DATA_WIDTH*DATA_COUNT  filtered samples, same packing as in_data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAP_COUNT)  tap index; tap 0 multiplies the newest sample.
- coef_data  in  COEF_WIDTH  signed coefficient.
- coef_busy  out  1  high when not IDLE; writes are dropped while high.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset effects:
  - Outputs: in_ready=0 during reset, 1 on the first cycle after; out_valid=0; out_data=0; coef_busy=0.
  - Delay lines, accumulator and decimation counter cleared.
  - FSM returns to IDLE.
  - Every coefficient reset to round(2^COEF_FRAC / TAP_COUNT), i.e. a moving average (4096 at defaults).
  - Reset mid-operation aborts the computation; no output is produced for it.
- FSM: IDLE -> MAC -> FINISH -> OUTPUT -> IDLE.
  - IDLE: in_ready=1. An accept (in_valid & in_ready) shifts each channel's delay line (new sample becomes tap 0; the oldest is dropped) and advances the decimation counter (0..DECIMATION-1).
  - If the counter was DECIMATION-1: counter wraps to 0 and the FSM goes to MAC. Otherwise the FSM stays in IDLE, so back-to-back accepts are allowed.
  - MAC: DATA_COUNT*TAP_COUNT cycles, channel-major (ch0 taps 0..TAP_COUNT-1, then ch1, ...). acc += sample*coef, full precision.
  - Accumulator width: DATA_WIDTH+COEF_WIDTH+clog2(TAP_COUNT). It is cleared at the start of each channel. At the end of each channel the rounded, saturated result is latched into that channel's output slot.
  - FINISH: 1 cycle; registers the complete out_data vector.
  - OUTPUT: out_valid=1, and out_data is held stable until out_ready=1. At that handshake edge out_valid drops and the FSM returns to IDLE, so in_ready=1 in the next cycle.
  - in_ready=0 in MAC, FINISH and OUTPUT.
- Latency: with a computing accept at edge E0, out_valid rises after edge E0 + DATA_COUNT*TAP_COUNT + 1 (17 cycles at defaults).
- Arithmetic:
  - Result = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, i.e. round half toward +inf.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - No intermediate wrap is allowed.
- Coefficients: a write takes effect at the edge where coef_we=1 in IDLE. Writes when coef_busy=1 are ignored.
- Boundary conditions:
  - in_valid arriving outside IDLE is held off by in_ready=0; the beat is never lost.
  - With out_ready tied high, OUTPUT lasts exactly 1 cycle.
  - Samples older than TAP_COUNT are discarded.
  - Delay lines start at zero after reset, so the first outputs are partial sums.

Test Plan:
- Defaults, out_ready=1, ten beats {1000,-1000} spaced 10 cycles -> outputs {125,-125},{250,-250}...{875,-875}, then {1000,-1000} from beat 8. out_valid rises 17 cycles after each accept.
- out_ready held low for 25 cycles -> out_valid=1, out_data stable and in_ready=0 throughout. Next beat is accepted 1 cycle after the out_ready handshake; no beat is lost.
- All taps written to 32767, steady input 32767 -> output saturates at 32767; steady input -32768 -> -32768.
- Tap0=16384, other taps 0: input 1 -> 1 (0.5 rounds up); input -1 -> 0; input 3 -> 2.
- coef_we pulsed during MAC with 0 -> coefficients unchanged, outputs as before; the same write issued in IDLE takes effect on the next computation.
- DECIMATION=2, DATA_COUNT=1, ten beats of 1000 -> 5 outputs: 250, 500, 750, 1000, 1000. Non-computing accepts keep in_ready high.
- reset asserted mid-MAC -> no output is produced; after release the first beat of 1000 yields 125.

Source files
------------

// File: rtl/multichannel_fir_filter.sv
// Multi-channel streaming FIR with one time-shared MAC, runtime coefficients,
// optional decimation and round-half-up / saturating output.
module multichannel_fir_filter #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_COUNT = 2,
    parameter int TAP_COUNT  = 8,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 15,
    parameter int DECIMATION = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH*DATA_COUNT-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH*DATA_COUNT-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             coef_we,
    input  logic [$clog2(TAP_COUNT)-1:0]     coef_addr,
    input  logic [COEF_WIDTH-1:0]            coef_data,
    output logic                             coef_busy
);

    localparam int TAP_W  = $clog2(TAP_COUNT);
    localparam int CH_W   = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam int DEC_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + TAP_W;
    localparam int RND_W  = ACC_W + 1;

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAP_COUNT - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(DATA_COUNT - 1);
    localparam logic [DEC_W-1:0] LAST_DEC = DEC_W'(DECIMATION - 1);

    localparam logic signed [COEF_WIDTH-1:0] COEF_INIT =
        COEF_WIDTH'(((64'sd1 <<< COEF_FRAC) + TAP_COUNT / 2) / TAP_COUNT);
    localparam logic signed [RND_W-1:0] ROUND_BIAS = RND_W'(64'sd1 <<< (COEF_FRAC - 1));
    localparam logic signed [RND_W-1:0] SAT_MAX    = RND_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [RND_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, FINISH, OUTPUT} state_t;

    state_t                        state_q;
    logic signed [DATA_WIDTH-1:0]  dly_q  [DATA_COUNT][TAP_COUNT];
    logic signed [COEF_WIDTH-1:0]  coef_q [TAP_COUNT];
    logic signed [DATA_WIDTH-1:0]  slot_q [DATA_COUNT];
    logic signed [ACC_W-1:0]       acc_q;
    logic [TAP_W-1:0]              tap_q;
    logic [CH_W-1:0]               ch_q;
    logic [DEC_W-1:0]              dec_q;
    logic [DATA_WIDTH*DATA_COUNT-1:0] out_data_q;
    logic                          out_valid_q;

    logic signed [DATA_WIDTH-1:0]  sample;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       acc_base;
    logic signed [ACC_W-1:0]       acc_d;
    logic signed [RND_W-1:0]       rnd_d;
    logic signed [DATA_WIDTH-1:0]  result_d;
    logic                          accept;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign coef_busy = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        sample = '0;
        for (int c = 0; c < DATA_COUNT; c++) begin
            if (ch_q == CH_W'(c)) begin
                sample = dly_q[c][tap_q];
            end
        end
    end

    // Accumulator restarts at tap 0 so each channel's sum is independent.
    assign prod     = PROD_W'(sample) * PROD_W'(coef_q[tap_q]);
    assign acc_base = (tap_q == '0) ? '0 : acc_q;
    assign acc_d    = acc_base + ACC_W'(prod);
    assign rnd_d    = (RND_W'(acc_d) + ROUND_BIAS) >>> COEF_FRAC;

    always_comb begin
        if (rnd_d > SAT_MAX) begin
            result_d = SAT_MAX[DATA_WIDTH-1:0];
        end else if (rnd_d < SAT_MIN) begin
            result_d = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result_d = rnd_d[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            ch_q        <= '0;
            dec_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int t = 0; t < TAP_COUNT; t++) begin
                coef_q[t] <= COEF_INIT;
            end
            for (int c = 0; c < DATA_COUNT; c++) begin
                slot_q[c] <= '0;
                for (int t = 0; t < TAP_COUNT; t++) begin
                    dly_q[c][t] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (coef_we) begin
                        coef_q[coef_addr] <= coef_data;
                    end
                    if (accept) begin
                        for (int c = 0; c < DATA_COUNT; c++) begin
                            dly_q[c][0] <= in_data[(DATA_COUNT-1-c)*DATA_WIDTH +: DATA_WIDTH];
                            for (int t = 1; t < TAP_COUNT; t++) begin
                                dly_q[c][t] <= dly_q[c][t-1];
                            end
                        end
                        if (dec_q == LAST_DEC) begin
                            dec_q   <= '0;
                            tap_q   <= '0;
                            ch_q    <= '0;
                            state_q <= MAC;
                        end else begin
                            dec_q <= dec_q + 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (tap_q == LAST_TAP) begin
                        for (int c = 0; c < DATA_COUNT; c++) begin
                            if (ch_q == CH_W'(c)) begin
                                slot_q[c] <= result_d;
                            end
                        end
                        tap_q <= '0;
                        if (ch_q == LAST_CH) begin
                            state_q <= FINISH;
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                FINISH: begin
                    for (int c = 0; c < DATA_COUNT; c++) begin
                        out_data_q[(DATA_COUNT-1-c)*DATA_WIDTH +: DATA_WIDTH] <= slot_q[c];
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multichannel_fir_filter.sv
// Randomised bench for multichannel_fir_filter against an arithmetic model of
// the filter (history arrays, coefficient array, round-half-up and clamp).
module tb_multichannel_fir_filter;

    localparam int DW      = 16;
    localparam int DC      = 2;
    localparam int TC      = 8;
    localparam int F       = 15;
    localparam int LATENCY = DC * TC + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] aInData = '0;
    logic        aInValid = 1'b0;
    logic        aInReady;
    logic [31:0] aOutData;
    logic        aOutValid;
    logic        aOutReady = 1'b1;
    logic        aCoefWe = 1'b0;
    logic [2:0]  aCoefAddr = '0;
    logic [15:0] aCoefData = '0;
    logic        aCoefBusy;

    logic [15:0] bInData = '0;
    logic        bInValid = 1'b0;
    logic        bInReady;
    logic [15:0] bOutData;
    logic        bOutValid;
    logic        bOutReady = 1'b1;
    logic        bCoefWe = 1'b0;
    logic [2:0]  bCoefAddr = '0;
    logic [15:0] bCoefData = '0;
    logic        bCoefBusy;

    longint      hist [DC][TC];
    longint      coef [TC];
    logic [31:0] expQ [$];
    int          accQ [$];
    int          cyc = 0;
    int          lastAccCyc = 0;
    int          hsCyc = 0;
    int          total = 0;
    int          bad = 0;
    int          bIdx = 0;
    logic [31:0] held = '0;
    bit          prevValid = 1'b0;
    longint      bExp [5] = '{250, 500, 750, 1000, 1000};

    multichannel_fir_filter dutA (
        .clk(clk), .reset(reset),
        .in_data(aInData), .in_valid(aInValid), .in_ready(aInReady),
        .out_data(aOutData), .out_valid(aOutValid), .out_ready(aOutReady),
        .coef_we(aCoefWe), .coef_addr(aCoefAddr), .coef_data(aCoefData),
        .coef_busy(aCoefBusy)
    );

    multichannel_fir_filter #(.DATA_COUNT(1), .DECIMATION(2)) dutB (
        .clk(clk), .reset(reset),
        .in_data(bInData), .in_valid(bInValid), .in_ready(bInReady),
        .out_data(bOutData), .out_valid(bOutValid), .out_ready(bOutReady),
        .coef_we(bCoefWe), .coef_addr(bCoefAddr), .coef_data(bCoefData),
        .coef_busy(bCoefBusy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelFilter();
        logic [31:0] r;
        longint acc;
        r = '0;
        for (int c = 0; c < DC; c++) begin
            acc = 0;
            for (int t = 0; t < TC; t++) begin
                acc += hist[c][t] * coef[t];
            end
            acc = (acc + (longint'(1) <<< (F - 1))) >>> F;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            r[(1-c)*16 +: 16] = 16'(acc);
        end
        return r;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < DC; c++) begin
            for (int t = 0; t < TC; t++) hist[c][t] = 0;
        end
        for (int t = 0; t < TC; t++) coef[t] = longint'(int'(real'(2 ** F) / real'(TC)));
        expQ.delete();
        accQ.delete();
    endtask

    // Each accepted beat enters the model history and queues one expected vector.
    task automatic applyStimulus(input logic [31:0] data);
        int n;
        n = 0;
        aInData  = data;
        aInValid = 1'b1;
        while (!aInReady && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!aInReady) begin
            checkOutput("accept timeout", 0, 1);
            aInValid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        aInValid   = 1'b0;
        lastAccCyc = cyc;
        for (int c = 0; c < DC; c++) begin
            for (int t = TC - 1; t > 0; t--) hist[c][t] = hist[c][t-1];
            hist[c][0] = longint'($signed(data[(1-c)*16 +: 16]));
        end
        expQ.push_back(modelFilter());
        accQ.push_back(cyc);
    endtask

    task automatic writeCoef(input int addr, input logic [15:0] data, input bit expectTaken);
        checkOutput("coef_busy", aCoefBusy, expectTaken ? 0 : 1);
        aCoefWe   = 1'b1;
        aCoefAddr = 3'(addr);
        aCoefData = data;
        @(posedge clk); #1;
        aCoefWe = 1'b0;
        if (expectTaken) coef[addr] = longint'($signed(data));
    endtask

    task automatic waitDrain(input bit randomReady);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            if (randomReady) aOutReady = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drain timeout", expQ.size(), 0);
            expQ.delete();
            accQ.delete();
        end
        aOutReady = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checkOutput("in_ready during reset", aInReady, 0);
        end
        checkOutput("out_valid reset", aOutValid, 0);
        checkOutput("out_data reset", aOutData, 0);
        checkOutput("coef_busy reset", aCoefBusy, 0);
        checkOutput("decim out_valid reset", bOutValid, 0);
        reset = 1'b0;
        #1;
        checkOutput("in_ready after reset", aInReady, 1);
        modelReset();
    endtask

    // Output side of dutA: latency on rise, hold under backpressure, data at handshake.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prevValid = 1'b0;
        end else begin
            if (aOutValid && !prevValid) begin
                if (accQ.size() == 0) checkOutput("unexpected output", 1, 0);
                else checkOutput("latency", cyc - accQ[0], LATENCY);
                held = aOutData;
            end
            if (aOutValid && !aOutReady) begin
                checkOutput("hold data", aOutData, held);
                checkOutput("in_ready while output", aInReady, 0);
            end
            if (aOutValid && aOutReady && expQ.size() != 0) begin
                checkOutput("ch0", $signed(aOutData[31:16]), $signed(expQ[0][31:16]));
                checkOutput("ch1", $signed(aOutData[15:0]), $signed(expQ[0][15:0]));
                void'(expQ.pop_front());
                void'(accQ.pop_front());
                hsCyc = cyc + 1;
            end
            prevValid = aOutValid;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset && bOutValid && bOutReady) begin
            if (bIdx < 5) checkOutput("decim out", $signed(bOutData), bExp[bIdx]);
            else checkOutput("decim extra output", 1, 0);
            bIdx++;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset(3);

        for (int i = 0; i < 10; i++) begin
            applyStimulus({16'sd1000, -16'sd1000});
            waitDrain(0);
        end

        aOutReady = 1'b0;
        applyStimulus({16'sd1200, -16'sd300});
        fork
            begin
                repeat (42) @(posedge clk);
                #1 aOutReady = 1'b1;
            end
            applyStimulus({-16'sd2000, 16'sd4000});
        join
        checkOutput("accept after handshake", lastAccCyc, hsCyc + 1);
        waitDrain(0);

        for (int t = 0; t < TC; t++) writeCoef(t, 16'sd32767, 1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus({16'sd32767, -16'sd32768});
            waitDrain(0);
        end

        writeCoef(0, 16'sd16384, 1);
        for (int t = 1; t < TC; t++) writeCoef(t, 16'sd0, 1);
        applyStimulus({16'sd1, -16'sd1});
        waitDrain(0);
        applyStimulus({16'sd3, -16'sd3});
        waitDrain(0);

        applyStimulus({16'sd500, 16'sd700});
        writeCoef(0, 16'sd0, 0);
        waitDrain(0);
        applyStimulus({16'sd500, 16'sd700});
        waitDrain(0);
        writeCoef(0, 16'sd0, 1);
        writeCoef(1, 16'sd8192, 1);
        applyStimulus({16'sd100, -16'sd100});
        waitDrain(0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus($urandom);
            if (i % 2 == 1) begin
                waitDrain(1);
                if ($urandom_range(0, 1) == 1) writeCoef($urandom_range(0, TC - 1), 16'($urandom), 1);
            end
        end
        waitDrain(1);

        applyStimulus({16'sd1000, -16'sd1000});
        repeat (5) @(posedge clk);
        #1;
        doReset(2);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("no output after abort", aOutValid, 0);
        applyStimulus({16'sd1000, -16'sd1000});
        waitDrain(0);

        for (int i = 0; i < 10; i++) begin
            int n;
            n = 0;
            bInData  = 16'sd1000;
            bInValid = 1'b1;
            while (!bInReady && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!bInReady) checkOutput("decim accept timeout", 0, 1);
            @(posedge clk); #1;
            bInValid = 1'b0;
            if (i % 2 == 0) checkOutput("decim ready kept", bInReady, 1);
        end
        repeat (30) @(posedge clk);
        #1;
        checkOutput("decim count", bIdx, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
